// File: rtl/alu_issue_queue.sv
// alu_issue_queue: command FIFO in front of the combinational 4-bit ALU.
// Head entry drives the ALU; its result is captured into a handshaked register.
module alu_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic [2:0] in_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [4:0] alu_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [4:0] res_data,
    output logic       res_err,
    output logic [7:0] res_count
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
    } cmd_t;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic empty;
    logic full;
    logic push;
    logic fire;
    logic take;
    cmd_t head;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign push  = in_valid && !full;
    assign fire  = !empty && (!res_valid || res_ready);
    assign take  = res_valid && res_ready;
    assign head  = mem[rd_ptr];

    assign in_ready = !full;
    assign alu_a    = empty ? 4'd0 : head.a;
    assign alu_b    = empty ? 4'd0 : head.b;
    assign alu_sel  = empty ? 3'd0 : head.sel;

    // Storage write; contents past the pointers are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: in_a, b: in_b, sel: in_sel};
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, fire})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Result register: capture on issue, drop valid on a bare handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= 5'd0;
            res_err   <= 1'b0;
        end else if (fire) begin
            res_valid <= 1'b1;
            res_data  <= alu_out;
            res_err   <= head.sel[2] && head.sel[1];
        end else if (take) begin
            res_valid <= 1'b0;
        end
    end

    // Consumed-result counter, wraps modulo 256.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_count <= 8'd0;
        end else if (take) begin
            res_count <= res_count + 8'd1;
        end
    end

endmodule
